// File: rtl/lsu_pkg.sv
// lsu_pkg: store/load size codes, FSM state encoding and load-size helper for load_store_unit.
package lsu_pkg;
    localparam logic [1:0] ST_B = 2'b00, ST_H = 2'b01, ST_W = 2'b10;
    localparam logic [2:0] LD_B = 3'b000, LD_H = 3'b001, LD_W = 3'b010, LD_BU = 3'b011, LD_HU = 3'b100;
    typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, DONE} state_e;
    // Loads reuse the store size encoding so alignment and strobe logic is shared.
    function automatic logic [1:0] ld_size(input logic [2:0] ld);
        return (ld == LD_H || ld == LD_HU) ? ST_H : (ld == LD_W) ? ST_W : ST_B;
    endfunction
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: word-wide data-memory handshake between the LSU (master) and memory (slave).
interface load_store_unit_if #(parameter int ADDR_W = 32);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    modport master (output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, input mem_gnt, mem_rvalid, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: shifts a (possibly two-word) read window down by the byte offset and sign/zero extends.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [63:0] raw_i,
    input  logic [1:0]  sel_i,
    input  logic [2:0]  load_i,
    output logic [31:0] data_o
);
    logic [31:0] sh;
    assign sh = 32'(raw_i >> {sel_i, 3'b000});
    always_comb begin
        data_o = load_i == LD_B  ? {{24{sh[7]}}, sh[7:0]} :
                 load_i == LD_BU ? {24'b0, sh[7:0]} :
                 load_i == LD_H  ? {{16{sh[15]}}, sh[15:0]} :
                 load_i == LD_HU ? {16'b0, sh[15:0]} : sh;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: one load/store per request over a word-wide memory handshake, stalling the core while busy.
// Define LSU_MISALIGNED_SPLIT_EN to split misaligned half/word accesses into two word transactions.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_we,
    input  logic [1:0]          req_store,
    input  logic [2:0]          req_load,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [31:0]         req_wdata,
    output logic                stall,
    output logic                done,
    output logic [31:0]         load_data,
    output logic                misaligned,
    load_store_unit_if.master   mem
);
`ifdef LSU_MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif
    if (DATA_W != 32 || ADDR_W < 3) begin : g_bad_param
        $error("load_store_unit: DATA_W must be 32 and ADDR_W >= 3");
    end
    state_e            state_q;
    logic              we_q, split_q, mis_q;
    logic [1:0]        size_q;
    logic [2:0]        load_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata0_q, load_data_q;
    logic [1:0]        req_size;
    logic              req_illegal, req_misal, mis_d, split_d;
    logic [31:0]       aligned;
    always_comb begin
        req_size    = req_we ? req_store : ld_size(req_load);
        req_illegal = req_we ? (req_store == 2'b11) : (req_load > 3'd4);
        req_misal   = (req_size == ST_H && req_addr[0]) || (req_size == ST_W && req_addr[1:0] != 2'b00);
        mis_d       = req_illegal || (req_misal && !SPLIT_EN);
        split_d     = req_misal && SPLIT_EN;
    end
    // The second word of a split read arrives last, so it forms the upper half of the window.
    lsu_load_align u_align (
        .raw_i  (state_q == RSP1 ? {mem.mem_rdata, rdata0_q} : {32'b0, mem.mem_rdata}),
        .sel_i  (addr_q[1:0]),
        .load_i (load_q),
        .data_o (aligned)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            split_q     <= 1'b0;
            mis_q       <= 1'b0;
            size_q      <= 2'b00;
            load_q      <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata0_q    <= '0;
            load_data_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    size_q  <= req_size;
                    load_q  <= req_load;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    mis_q   <= mis_d;
                    split_q <= split_d;
                    state_q <= mis_d ? DONE : REQ0;
                end
                REQ0: if (mem.mem_gnt) state_q <= we_q ? (split_q ? REQ1 : DONE) : RSP0;
                RSP0: if (mem.mem_rvalid) begin
                    rdata0_q <= mem.mem_rdata;
                    if (!split_q) load_data_q <= aligned;
                    state_q <= split_q ? REQ1 : DONE;
                end
                REQ1: if (mem.mem_gnt) state_q <= we_q ? DONE : RSP1;
                RSP1: if (mem.mem_rvalid) begin
                    load_data_q <= aligned;
                    state_q     <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    logic              in_req0, in_req1;
    logic [3:0]        mask;
    logic [7:0]        strb8;
    logic [63:0]       wsh;
    logic [31:0]       wrep;
    logic [ADDR_W-1:0] base;
    always_comb begin
        in_req0 = state_q == REQ0;
        in_req1 = state_q == REQ1;
        mask    = size_q == ST_B ? 4'b0001 : size_q == ST_H ? 4'b0011 : 4'b1111;
        strb8   = {4'b0, mask} << addr_q[1:0];
        wsh     = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
        wrep    = size_q == ST_B ? {4{wdata_q[7:0]}} : size_q == ST_H ? {2{wdata_q[15:0]}} : wdata_q;
        base    = {addr_q[ADDR_W-1:2], 2'b00};
    end
    assign mem.mem_req   = in_req0 || in_req1;
    assign mem.mem_we    = mem.mem_req && we_q;
    assign mem.mem_addr  = in_req0 ? base : in_req1 ? base + ADDR_W'(4) : '0;
    assign mem.mem_wstrb = !mem.mem_we ? 4'b0000 : in_req1 ? strb8[7:4] : strb8[3:0];
    assign mem.mem_wdata = !mem.mem_we ? 32'b0 : split_q ? (in_req1 ? wsh[63:32] : wsh[31:0]) : wrep;
    assign stall      = (state_q == IDLE && req_valid) || (state_q != IDLE && state_q != DONE);
    assign done       = state_q == DONE;
    assign misaligned = done && mis_q;
    assign load_data  = load_data_q;
endmodule
